ctrl_pipe_queue: RTL

Parametrised multi-stage pipeline register for ALU control and flag-enable fields, carried alongside the datapath between decode and execute/writeback.
Generalises the fixed 3-bit + 1-bit single-stage control register:
- configurable control width and stage depth
- per-stage valid bit
- global stall (hold)
- per-stage flush (bubble insertion)
Feeds the ALU control input and the flag-register write enable at the pipe tail.

---
 rtl/ctrl_pipe_pkg.sv | 19 +
 rtl/ctrl_pipe_stage.sv | 37 +++
 rtl/ctrl_pipe_queue.sv | 88 ++++++++
 3 files changed

// File: rtl/ctrl_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_pkg
// Shared definitions for the ALU control / flag-enable pipeline queue.
//   DEF_CTRL_W      : default width of the ALU control field
//   DEF_BUBBLE_CTRL : default control value carried by a bubble
//   ctrl_entry_t    : one pipeline entry {valid, ctrl, flag_en} at default width
// ---------------------------------------------------------------------------
package ctrl_pipe_pkg;

    localparam int                    DEF_CTRL_W      = 3;
    localparam logic [DEF_CTRL_W-1:0] DEF_BUBBLE_CTRL = '0;

    typedef struct packed {
        logic                  valid;
        logic [DEF_CTRL_W-1:0] ctrl;
        logic                  flag_en;
    } ctrl_entry_t;

endpackage

// File: rtl/ctrl_pipe_stage.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_stage
// One pipeline register holding a single control entry.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset, loads BUBBLE
//   en    : 1 = load d at this edge, 0 = hold
//   clr   : synchronous clear to BUBBLE, wins over en
//   d     : entry from the previous stage (or the pipe head)
//   q     : registered entry
// ---------------------------------------------------------------------------
module ctrl_pipe_stage
    import ctrl_pipe_pkg::*;
#(
    parameter type    entry_t = ctrl_entry_t,
    parameter entry_t BUBBLE  = '0
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   en,
    input  logic   clr,
    input  entry_t d,
    output entry_t q
);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its neighbour's pre-edge value and the chain shifts cleanly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= BUBBLE;
        end else if (clr) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ctrl_pipe_queue.sv
// ---------------------------------------------------------------------------
// ctrl_pipe_queue
// DEPTH-stage pipeline carrying ALU control and flag-write enable alongside
// the datapath, with per-stage valid, global stall and per-stage flush.
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset, all stages become bubbles
//   stall       : 1 = every stage holds at this edge
//   flush       : flush[i] = 1 loads a bubble into stage i (beats stall)
//   in_valid    : head entry is a real instruction
//   in_ctrl     : ALU control for the head entry
//   in_flag_en  : flag-write enable for the head entry
//   in_ready    : ~stall; upstream must hold in_* while low
//   stage_valid : valid bit per stage, bit 0 = first stage
//   stage_ctrl  : control per stage, stage i at [i*CTRL_W +: CTRL_W]
//   out_valid   : valid of the last stage
//   out_ctrl    : control of the last stage
//   out_flag_en : flag enable of the last stage, masked by out_valid
// ---------------------------------------------------------------------------
module ctrl_pipe_queue
    import ctrl_pipe_pkg::*;
#(
    parameter int                CTRL_W      = DEF_CTRL_W,
    parameter int                DEPTH       = 2,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(DEF_BUBBLE_CTRL)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    stall,
    input  logic [DEPTH-1:0]        flush,
    input  logic                    in_valid,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic                    in_flag_en,
    output logic                    in_ready,
    output logic [DEPTH-1:0]        stage_valid,
    output logic [DEPTH*CTRL_W-1:0] stage_ctrl,
    output logic                    out_valid,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic                    out_flag_en
);

    // Same layout as ctrl_entry_t, resized to this instance's CTRL_W.
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic              flag_en;
    } entry_t;

    localparam entry_t BUBBLE = '{valid: 1'b0, ctrl: BUBBLE_CTRL, flag_en: 1'b0};

    entry_t head;
    entry_t q [DEPTH];

    assign head = '{valid: in_valid, ctrl: in_ctrl, flag_en: in_flag_en};

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        entry_t d;

        if (i == 0) begin : g_head
            assign d = head;
        end else begin : g_chain
            assign d = q[i-1];
        end

        // Flush targets the destination register, so it is wired as the
        // clear of stage i and overrides the hold from stall.
        ctrl_pipe_stage #(
            .entry_t (entry_t),
            .BUBBLE  (BUBBLE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .en    (~stall),
            .clr   (flush[i]),
            .d     (d),
            .q     (q[i])
        );

        assign stage_valid[i]                 = q[i].valid;
        assign stage_ctrl[i*CTRL_W +: CTRL_W] = q[i].ctrl;
    end

    assign in_ready    = ~stall;
    assign out_valid   = q[DEPTH-1].valid;
    assign out_ctrl    = q[DEPTH-1].ctrl;
    // Bubbles may carry a stale flag_en bit; never let it reach the flags.
    assign out_flag_en = q[DEPTH-1].flag_en & q[DEPTH-1].valid;

endmodule
